// File: rtl/branch_target_predictor.sv
// -----------------------------------------------------------------------------
// branch_target_predictor
//
// Direct-mapped branch target buffer with a 2-bit saturating direction counter
// per entry. Fetch looks up PCF combinationally. The EX stage resolves branches,
// flags mispredictions and trains the table one cycle later.
//
// Ports
//   clk            : CPU clock; all state changes on the rising edge
//   CpuRst         : synchronous active-high reset
//   PCF            : fetch PC to look up
//   PredTakenF     : predicted taken for PCF
//   PredTargetF    : predicted target for PCF (0 on a miss)
//   BranchTypeE    : EX branch type; 3'b000 means not a branch
//   StallE         : EX held; suppresses training and counting
//   PCE            : PC of the EX instruction
//   BranchE        : resolved branch outcome
//   BranchTargetE  : resolved branch target
//   PredTakenE     : fetch-time prediction, piped to EX
//   PredTargetE    : fetch-time predicted target, piped to EX
//   MispredictE    : redirect required
//   CorrectPCE     : redirect PC
//   BranchCnt      : resolved-branch counter (saturating)
//   MispredCnt     : misprediction counter (saturating)
// -----------------------------------------------------------------------------
module branch_target_predictor #(
  parameter int ENTRIES = 16
) (
  input  logic        clk,
  input  logic        CpuRst,
  input  logic [31:0] PCF,
  output logic        PredTakenF,
  output logic [31:0] PredTargetF,
  input  logic [2:0]  BranchTypeE,
  input  logic        StallE,
  input  logic [31:0] PCE,
  input  logic        BranchE,
  input  logic [31:0] BranchTargetE,
  input  logic        PredTakenE,
  input  logic [31:0] PredTargetE,
  output logic        MispredictE,
  output logic [31:0] CorrectPCE,
  output logic [31:0] BranchCnt,
  output logic [31:0] MispredCnt
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 30 - IDX_W;

  logic [ENTRIES-1:0] valid;
  logic [1:0]         ctr        [ENTRIES];
  logic [TAG_W-1:0]   tag_mem    [ENTRIES];
  logic [31:0]        target_mem [ENTRIES];

  logic [IDX_W-1:0] idx_f, idx_e;
  logic [TAG_W-1:0] tag_f, tag_e;
  logic             hit_f, hit_e, upd_e;

  // Byte-offset bits never participate in indexing or tagging.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{PCF[1:0], PCE[1:0]};

  assign idx_f = PCF[IDX_W+1:2];
  assign tag_f = PCF[31:IDX_W+2];
  assign idx_e = PCE[IDX_W+1:2];
  assign tag_e = PCE[31:IDX_W+2];

  // Fetch lookup reads the registered table only, so a same-cycle update to
  // the same index is seen on the following cycle.
  assign hit_f       = valid[idx_f] && (tag_mem[idx_f] == tag_f);
  assign PredTakenF  = hit_f && ctr[idx_f][1];
  assign PredTargetF = hit_f ? target_mem[idx_f] : 32'h0;

  assign hit_e = valid[idx_e] && (tag_mem[idx_e] == tag_e);
  assign upd_e = (BranchTypeE != 3'b000) && !StallE && !CpuRst;

  // A taken branch that was also predicted taken can still redirect when the
  // predicted target was stale.
  assign MispredictE = upd_e && ((BranchE != PredTakenE) ||
                                 (BranchE && PredTakenE && (PredTargetE != BranchTargetE)));
  assign CorrectPCE  = BranchE ? BranchTargetE : (PCE + 32'd4);

  // Valid bits and direction counters: these have defined reset values.
  // NOTE: only state with a defined reset value sits under the reset branch;
  // tag/target storage is left unreset in its own block so it can map to RAM.
  always_ff @(posedge clk) begin
    if (CpuRst) begin
      valid <= '0;
      for (int i = 0; i < ENTRIES; i++) ctr[i] <= 2'b01;
    end else if (upd_e) begin
      if (hit_e) begin
        if (BranchE) ctr[idx_e] <= (ctr[idx_e] == 2'b11) ? 2'b11 : ctr[idx_e] + 2'd1;
        else         ctr[idx_e] <= (ctr[idx_e] == 2'b00) ? 2'b00 : ctr[idx_e] - 2'd1;
      end else if (BranchE) begin
        valid[idx_e] <= 1'b1;
        ctr[idx_e]   <= 2'b10;
      end
    end
  end

  // Tag/target storage. A taken resolution always writes the target, whether
  // it refreshes a hit or allocates over a miss.
  always_ff @(posedge clk) begin
    if (upd_e && BranchE) begin
      target_mem[idx_e] <= BranchTargetE;
      if (!hit_e) tag_mem[idx_e] <= tag_e;
    end
  end

  // Performance counters, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (CpuRst) begin
      BranchCnt  <= '0;
      MispredCnt <= '0;
    end else begin
      if (upd_e && (BranchCnt != '1))        BranchCnt  <= BranchCnt + 32'd1;
      if (MispredictE && (MispredCnt != '1)) MispredCnt <= MispredCnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_branch_target_predictor.sv
// -----------------------------------------------------------------------------
// Directed testbench for branch_target_predictor (ENTRIES = 16).
// Inputs change 1 time unit after a rising edge; combinational outputs are
// sampled before the next edge and registered results after it.
// -----------------------------------------------------------------------------
module tb_branch_target_predictor;

  logic        clk = 1'b0;
  logic        CpuRst;
  logic [31:0] PCF;
  logic        PredTakenF;
  logic [31:0] PredTargetF;
  logic [2:0]  BranchTypeE;
  logic        StallE;
  logic [31:0] PCE;
  logic        BranchE;
  logic [31:0] BranchTargetE;
  logic        PredTakenE;
  logic [31:0] PredTargetE;
  logic        MispredictE;
  logic [31:0] CorrectPCE;
  logic [31:0] BranchCnt;
  logic [31:0] MispredCnt;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [2:0] NOBR = 3'b000;
  localparam logic [2:0] BEQ  = 3'b001;

  branch_target_predictor #(.ENTRIES(16)) dut (
    .clk(clk), .CpuRst(CpuRst), .PCF(PCF), .PredTakenF(PredTakenF),
    .PredTargetF(PredTargetF), .BranchTypeE(BranchTypeE), .StallE(StallE),
    .PCE(PCE), .BranchE(BranchE), .BranchTargetE(BranchTargetE),
    .PredTakenE(PredTakenE), .PredTargetE(PredTargetE),
    .MispredictE(MispredictE), .CorrectPCE(CorrectPCE),
    .BranchCnt(BranchCnt), .MispredCnt(MispredCnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ex_idle();
    BranchTypeE = NOBR; StallE = 1'b0; BranchE = 1'b0;
    PredTakenE = 1'b0; PredTargetE = 32'h0; BranchTargetE = 32'h0;
  endtask

  task automatic ex_br(input logic [31:0] pc, input logic taken, input logic [31:0] tgt,
                       input logic ptaken, input logic [31:0] ptgt);
    BranchTypeE = BEQ; StallE = 1'b0; PCE = pc; BranchE = taken;
    BranchTargetE = tgt; PredTakenE = ptaken; PredTargetE = ptgt;
  endtask

  initial begin
    CpuRst = 1'b1; PCF = 32'h40; PCE = 32'h0;
    ex_idle();
    tick(); tick();
    CpuRst = 1'b0;
    #1;

    // Reset state
    check("rst_predtaken",  {31'b0, PredTakenF}, 32'h0);
    check("rst_predtarget", PredTargetF, 32'h0);
    check("rst_mispred",    {31'b0, MispredictE}, 32'h0);
    check("rst_branchcnt",  BranchCnt, 32'h0);
    check("rst_mispredcnt", MispredCnt, 32'h0);

    // First taken branch at 0x40 allocates the entry
    ex_br(32'h40, 1'b1, 32'h100, 1'b0, 32'h0);
    #1;
    check("alloc_mispred",  {31'b0, MispredictE}, 32'h1);
    check("alloc_correct",  CorrectPCE, 32'h100);
    check("alloc_no_bypass", {31'b0, PredTakenF}, 32'h0);
    tick();
    ex_idle();
    #1;
    check("alloc_predtaken",  {31'b0, PredTakenF}, 32'h1);
    check("alloc_predtarget", PredTargetF, 32'h100);
    check("alloc_mispredcnt", MispredCnt, 32'h1);
    check("alloc_branchcnt",  BranchCnt, 32'h1);

    // Counter walk: NT, T, NT, NT, NT => 01, 10, 01, 00, 00
    ex_br(32'h40, 1'b0, 32'h0, 1'b1, 32'h100);
    #1;
    check("walk1_mispred", {31'b0, MispredictE}, 32'h1);
    check("walk1_correct", CorrectPCE, 32'h44);
    tick(); ex_idle(); #1;
    check("walk1_pred", {31'b0, PredTakenF}, 32'h0);

    ex_br(32'h40, 1'b1, 32'h100, 1'b0, 32'h100);
    #1;
    check("walk2_mispred", {31'b0, MispredictE}, 32'h1);
    tick(); ex_idle(); #1;
    check("walk2_pred", {31'b0, PredTakenF}, 32'h1);

    ex_br(32'h40, 1'b0, 32'h0, 1'b1, 32'h100);
    tick(); ex_idle(); #1;
    check("walk3_pred", {31'b0, PredTakenF}, 32'h0);

    ex_br(32'h40, 1'b0, 32'h0, 1'b0, 32'h100);
    #1;
    check("walk4_mispred", {31'b0, MispredictE}, 32'h0);
    tick(); ex_idle(); #1;
    check("walk4_pred", {31'b0, PredTakenF}, 32'h0);

    ex_br(32'h40, 1'b0, 32'h0, 1'b0, 32'h100);
    tick(); ex_idle(); #1;
    check("walk5_pred",   {31'b0, PredTakenF}, 32'h0);
    check("walk5_target", PredTargetF, 32'h100);
    check("walk_branchcnt",  BranchCnt, 32'd6);
    check("walk_mispredcnt", MispredCnt, 32'd4);

    // Up-walk at 0x40 from 00: T -> 01 (not taken), T -> 10 (taken)
    ex_br(32'h40, 1'b1, 32'h100, 1'b0, 32'h100);
    tick(); ex_idle(); #1;
    check("upwalk1_pred", {31'b0, PredTakenF}, 32'h0);
    ex_br(32'h40, 1'b1, 32'h100, 1'b0, 32'h100);
    tick(); ex_idle(); #1;
    check("upwalk2_pred", {31'b0, PredTakenF}, 32'h1);
    // B=8, M=6

    // Entry at 0x44 (index 1): allocate, wrong target, then correct
    PCF = 32'h44;
    ex_br(32'h44, 1'b1, 32'h200, 1'b0, 32'h0);
    tick();
    ex_br(32'h44, 1'b1, 32'h300, 1'b1, 32'h200);
    #1;
    check("tgt_mispred", {31'b0, MispredictE}, 32'h1);
    tick();
    ex_br(32'h44, 1'b1, 32'h300, 1'b1, 32'h300);
    #1;
    check("tgt_ok", {31'b0, MispredictE}, 32'h0);
    check("tgt_updated", PredTargetF, 32'h300);
    tick(); ex_idle(); #1;
    check("tgt_branchcnt",  BranchCnt, 32'd11);
    check("tgt_mispredcnt", MispredCnt, 32'd8);

    // CorrectPCE wraps on fall-through
    PCE = 32'hFFFF_FFFC;
    #1;
    check("wrap_correct", CorrectPCE, 32'h0);

    // 0x80 shares index 0 with 0x40 but has a different tag
    ex_br(32'h80, 1'b1, 32'h180, 1'b0, 32'h0);
    tick(); ex_idle();
    PCF = 32'h40; #1;
    check("repl_old_taken",  {31'b0, PredTakenF}, 32'h0);
    check("repl_old_target", PredTargetF, 32'h0);
    PCF = 32'h80; #1;
    check("repl_new_taken",  {31'b0, PredTakenF}, 32'h1);
    check("repl_new_target", PredTargetF, 32'h180);
    // B=12, M=9

    // Stall for three cycles, then release
    ex_br(32'h80, 1'b0, 32'h0, 1'b1, 32'h180);
    StallE = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("stall_mispred", {31'b0, MispredictE}, 32'h0);
      tick();
    end
    check("stall_branchcnt", BranchCnt, 32'd12);
    StallE = 1'b0;
    #1;
    check("release_mispred", {31'b0, MispredictE}, 32'h1);
    tick(); ex_idle(); #1;
    check("release_branchcnt",  BranchCnt, 32'd13);
    check("release_mispredcnt", MispredCnt, 32'd10);

    // NOBRANCH ignores the branch-outcome inputs
    BranchTypeE = NOBR; PCE = 32'h80; BranchE = 1'b1; BranchTargetE = 32'h999;
    PredTakenE = 1'b0;
    #1;
    check("nobr_mispred", {31'b0, MispredictE}, 32'h0);
    tick(); ex_idle(); #1;
    check("nobr_branchcnt", BranchCnt, 32'd13);
    check("nobr_target",    PredTargetF, 32'h180);

    // Reset wins over a simultaneous taken update
    CpuRst = 1'b1;
    ex_br(32'hC0, 1'b1, 32'h500, 1'b0, 32'h0);
    #1;
    check("rstupd_mispred", {31'b0, MispredictE}, 32'h0);
    tick();
    CpuRst = 1'b0; ex_idle();
    PCF = 32'hC0; #1;
    check("rstupd_taken",  {31'b0, PredTakenF}, 32'h0);
    check("rstupd_target", PredTargetF, 32'h0);
    PCF = 32'h80; #1;
    check("rstupd_old_taken", {31'b0, PredTakenF}, 32'h0);
    check("rstupd_branchcnt",  BranchCnt, 32'h0);
    check("rstupd_mispredcnt", MispredCnt, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
